// File: rtl/cpu_pkg.sv
// Shared opcodes, sequencer states and instruction field positions
// for the 16-bit accumulator CPU control path.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOT   = 4'b0101,
    OP_LOAD  = 4'b0110,
    OP_STORE = 4'b0111,
    OP_JUMP  = 4'b1000,
    OP_NOP   = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } seq_state_t;

  localparam int OP_MSB      = 3;
  localparam int OP_LSB      = 0;
  localparam int RS_MSB      = 15;
  localparam int RS_LSB      = 14;
  localparam int LD_DST_MSB  = 5;
  localparam int LD_DST_LSB  = 4;
  localparam int LD_ADDR_MSB = 7;
  localparam int LD_ADDR_LSB = 6;
  localparam int JMP_LSB     = 4;

  function automatic logic is_alu(input logic [3:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/sequencer_pc.sv
// Program counter for the instruction sequencer: clear, increment,
// load and hold, plus a flag for the last program address.
module sequencer_pc #(
  parameter int W    = 5,
  parameter int LAST = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_pc,
  output logic [W-1:0] pc,
  output logic         is_last
);

  localparam logic [W-1:0] LAST_PC = W'(LAST);

  logic [W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      clr:     pc_d = '0;
      load:    pc_d = load_pc;
      inc:     pc_d = pc_q + W'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign is_last = (pc_q == LAST_PC);

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller for the accumulator CPU.
// Define SEQ_JUMP_EN to make opcode 4'b1000 an absolute JUMP.
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
  output logic [3:0]                       alu_op,
  output logic                             alu_en,
  output logic [1:0]                       reg_sel,
  output logic [1:0]                       addr_sel,
  output logic                             reg_we,
  output logic                             mem_req,
  output logic                             mem_we,
  input  logic                             mem_ack,
  output logic                             busy,
  output logic                             done,
  output logic                             illegal_op
);

  seq_state_t state_q, state_d;

  logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
  logic illegal_q, illegal_d;

  logic pc_clr, pc_inc, pc_load;
  logic pc_last, retire;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc;
  logic [BITS_FOR_INSTRUCTIONS-1:0] jump_pc;

  logic [3:0] op;
  logic op_load, op_store;
  logic unused_ir;

  assign op       = ir_q[OP_MSB:OP_LSB];
  assign op_load  = (op == OP_LOAD);
  assign op_store = (op == OP_STORE);
  assign jump_pc  = ir_q[JMP_LSB +: BITS_FOR_INSTRUCTIONS];
  assign unused_ir = ^ir_q;

  sequencer_pc #(
    .W    (BITS_FOR_INSTRUCTIONS),
    .LAST (NUMBER_OF_INSTRUCTIONS - 1)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pc_clr),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc (jump_pc),
    .pc      (pc),
    .is_last (pc_last)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    retire    = 1'b0;
    alu_en    = 1'b0;
    reg_we    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_clr    = 1'b1;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu(op):          state_d = S_EXEC;
          op_load || op_store: state_d = S_MEM;
          op == OP_NOP:        retire  = 1'b1;
`ifdef SEQ_JUMP_EN
          op == OP_JUMP: begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
`endif
          default: begin
            retire    = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        state_d = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = op_store;
        if (mem_ack) begin
          if (op_store) retire  = 1'b1;
          else          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The last program address halts in place; there is no wrap.
    if (retire) begin
      if (pc_last) begin
        state_d = S_HALT;
      end else begin
        pc_inc  = 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign instruction_address = pc;
  assign alu_op     = op;
  assign reg_sel    = op_load ? ir_q[LD_DST_MSB:LD_DST_LSB]
                              : ir_q[RS_MSB:RS_LSB];
  assign addr_sel   = ir_q[LD_ADDR_MSB:LD_ADDR_LSB];
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign done       = (state_q == S_HALT);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer against an
// instruction-level reference model expanded into per-cycle outputs.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] instruction;
  logic [4:0]  instruction_address;
  logic [3:0]  alu_op;
  logic        alu_en;
  logic [1:0]  reg_sel;
  logic [1:0]  addr_sel;
  logic        reg_we;
  logic        mem_req;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        illegal_op;

  logic [15:0] prog [32];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] v;
    bit          ops;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   req_cnt = 0;

`ifdef SEQ_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  assign instruction = prog[instruction_address];

  instruction_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .instruction         (instruction),
    .instruction_address (instruction_address),
    .alu_op              (alu_op),
    .alu_en              (alu_en),
    .reg_sel             (reg_sel),
    .addr_sel            (addr_sel),
    .reg_we              (reg_we),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_ack             (mem_ack),
    .busy                (busy),
    .done                (done),
    .illegal_op          (illegal_op)
  );

  function automatic logic [31:0] pack(
    logic b, logic d, logic [4:0] a, logic ae, logic we,
    logic mr, logic mw, logic il, logic [3:0] op,
    logic [1:0] rs, logic [1:0] as);
    return {12'd0, b, d, a, ae, we, mr, mw, il, op, rs, as};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(busy, done, instruction_address, alu_en, reg_we,
                mem_req, mem_we, illegal_op, alu_op, reg_sel, addr_sel);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: ack after the planned number of request cycles,
  // random noise on mem_ack whenever no request is pending.
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      req_cnt++;
      if (lat_q.size() == 0) mem_ack = 1'b1;
      else                   mem_ack = (req_cnt >= lat_q[0]);
      if (mem_ack) begin
        if (lat_q.size() != 0) void'(lat_q.pop_front());
        req_cnt = 0;
      end
    end else begin
      req_cnt = 0;
      mem_ack = 1'($urandom_range(0, 1));
    end
  end

  function automatic void push(logic [31:0] v, bit ops);
    exp_t e;
    e.v   = v;
    e.ops = ops;
    exp_q.push_back(e);
  endfunction

  // Walk the program one instruction at a time using the latency table.
  task automatic build_model();
    int          pc;
    int          n;
    int          guard;
    bit          ill;
    bit          halted;
    bit          ret;
    logic [15:0] w;
    logic [3:0]  op;
    logic [1:0]  rs;
    logic [4:0]  a;
    exp_q.delete();
    lat_q.delete();
    pc = 0;
    ill = 1'b0;
    halted = 1'b0;
    guard = 0;
    w = '0;
    while (!halted && guard < 200) begin
      guard++;
      w  = prog[pc];
      op = w[3:0];
      rs = (op == 4'h6) ? w[5:4] : w[15:14];
      a  = 5'(pc);
      ret = 1'b1;
      push(pack(1, 0, a, 0, 0, 0, 0, ill, 4'h0, 2'b0, 2'b0), 1'b0);
      push(pack(1, 0, a, 0, 0, 0, 0, ill, op, rs, w[7:6]), 1'b1);
      if (op <= 4'h5) begin
        push(pack(1, 0, a, 1, 0, 0, 0, ill, op, rs, w[7:6]), 1'b1);
        push(pack(1, 0, a, 0, 1, 0, 0, ill, op, rs, w[7:6]), 1'b1);
      end else if (op == 4'h6 || op == 4'h7) begin
        n = $urandom_range(1, 4);
        lat_q.push_back(n);
        repeat (n)
          push(pack(1, 0, a, 0, 0, 1, op == 4'h7, ill, op, rs, w[7:6]), 1'b1);
        if (op == 4'h6)
          push(pack(1, 0, a, 0, 1, 0, 0, ill, op, rs, w[7:6]), 1'b1);
      end else if (op == 4'hF) begin
        ret = 1'b1;
      end else if (JUMP_EN && op == 4'h8) begin
        pc  = int'(w[8:4]);
        ret = 1'b0;
      end else begin
        ill = 1'b1;
      end
      if (ret) begin
        if (pc == 31) halted = 1'b1;
        else          pc++;
      end
    end
    op = w[3:0];
    rs = (op == 4'h6) ? w[5:4] : w[15:14];
    repeat (3)
      push(pack(0, 1, 5'd31, 0, 0, 0, 0, ill, op, rs, w[7:6]), 1'b1);
  endtask

  task automatic gen_random();
    logic [15:0] w;
    logic [3:0]  op;
    int          k;
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      k = $urandom_range(0, 11);
      if (k <= 7)       op = 4'(k);
      else if (k == 8)  op = 4'hF;
      else if (k == 9)  op = 4'h8;
      else if (k == 10) op = 4'(9 + $urandom_range(0, 5));
      else              op = 4'(6 + $urandom_range(0, 1));
      if (op == 4'h8) begin
        if (i < 31) w[8:4] = 5'($urandom_range(i + 1, 31));
        else        op = 4'hF;
      end
      w[3:0] = op;
      prog[i] = w;
    end
  endtask

  task automatic run_prog(string tag);
    exp_t e;
    int   idx;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s.c%0d", tag, idx),
            e.ops ? dut_vec() : (dut_vec() & 32'hFFFF_FF00), e.v);
      start = e.v[19] ? 1'($urandom_range(0, 1)) : 1'b0;
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) prog[i] = 16'h000F;

    repeat (2) @(negedge clk);
    check("rst_hold", dut_vec(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle", dut_vec(), 32'd0);

    // Reset in the middle of an ALU instruction
    prog[0] = 16'h4000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("exec_alu_en", 32'(alu_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async", dut_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_resume", dut_vec(), 32'd0);

    for (int i = 0; i < 32; i++) prog[i] = 16'h000F;
    run_prog("nop32");

    prog[0]  = 16'h4000;
    prog[3]  = 16'h0078;
    prog[9]  = 16'h0066;
    prog[10] = 16'h8007;
    run_prog("jump");

    for (int r = 0; r < 5; r++) begin
      gen_random();
      run_prog($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
